// File: rtl/axis_pixel_proc.sv
// AXI4-Stream per-lane pixel processor (pass / invert / threshold / saturating add)
// with a skid-buffered handshake. Define AXIS_PIXEL_PROC_STATS_EN for beat/packet counters.
module axis_pixel_proc #(
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = 8
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic [1:0]            cfg_mode,
  input  logic [LANE_WIDTH-1:0] cfg_operand,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_ready,
  output logic [31:0]           pkt_count,
  output logic [31:0]           beat_count
);

  localparam int NLANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [LANE_WIDTH-1:0] LANE_MAX = '1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                  state_q;
  logic [1:0]              mode_q;
  logic [LANE_WIDTH-1:0]   operand_q;

  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
  logic                    out_last_q,  out_last_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic                    skid_last_q, skid_last_d;
  logic                    s_ready_q;

  logic [1:0]              eff_mode;
  logic [LANE_WIDTH-1:0]   eff_operand;
  logic [DATA_WIDTH-1:0]   proc_data;
  logic                    accept, drain;

  function automatic logic [LANE_WIDTH-1:0] lane_op(input logic [1:0]            mode,
                                                    input logic [LANE_WIDTH-1:0] x,
                                                    input logic [LANE_WIDTH-1:0] op);
    logic [LANE_WIDTH:0]   sum;
    logic [LANE_WIDTH-1:0] y;
    sum = {1'b0, x} + {1'b0, op};
    case (mode)
      2'b00:   y = x;
      2'b01:   y = LANE_MAX - x;
      2'b10:   y = (x >= op) ? LANE_MAX : '0;
      default: y = sum[LANE_WIDTH] ? LANE_MAX : sum[LANE_WIDTH-1:0];
    endcase
    return y;
  endfunction

  assign accept       = s_axis_valid && s_ready_q;
  assign drain        = out_valid_q && m_axis_ready;
  assign s_axis_ready = s_ready_q;
  assign m_axis_valid = out_valid_q;
  assign m_axis_data  = out_data_q;
  assign m_axis_tlast = out_last_q;

  // The first beat of a packet uses the live config; later beats use the latched copy.
  assign eff_mode    = (state_q == IDLE) ? cfg_mode    : mode_q;
  assign eff_operand = (state_q == IDLE) ? cfg_operand : operand_q;

  always_comb begin
    proc_data = '0;
    for (int i = 0; i < NLANES; i++) begin
      proc_data[i*LANE_WIDTH +: LANE_WIDTH] =
        lane_op(eff_mode, s_axis_data[i*LANE_WIDTH +: LANE_WIDTH], eff_operand);
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (skid_valid_q) begin
      if (drain) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || drain) begin
        out_valid_d = 1'b1;
        out_data_d  = proc_data;
        out_last_d  = s_axis_tlast;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = proc_data;
        skid_last_d  = s_axis_tlast;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      s_ready_q    <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      s_ready_q    <= !skid_valid_d;
    end
  end

  // NOTE: skid payload is qualified by skid_valid_q, so it needs no reset.
  always_ff @(posedge axi_clk) begin
    skid_data_q <= skid_data_d;
    skid_last_q <= skid_last_d;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      operand_q <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          mode_q    <= cfg_mode;
          operand_q <= cfg_operand;
          state_q   <= s_axis_tlast ? IDLE : IN_PKT;
        end
        default: if (s_axis_tlast) state_q <= IDLE;
      endcase
    end
  end

`ifdef AXIS_PIXEL_PROC_STATS_EN
  logic [31:0] pkt_count_q, beat_count_q;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      pkt_count_q  <= '0;
      beat_count_q <= '0;
    end else if (drain) begin
      beat_count_q <= beat_count_q + 32'd1;
      if (out_last_q) pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign beat_count = beat_count_q;
`else
  assign pkt_count  = '0;
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_axis_pixel_proc.sv
// Directed and reference-model bench for axis_pixel_proc (32-bit data, 8-bit lanes).
// Counter expectations follow AXIS_PIXEL_PROC_STATS_EN.
module tb_axis_pixel_proc;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          axi_reset;
  logic [1:0]    cfg_mode;
  logic [LW-1:0] cfg_operand;
  logic          s_valid, s_tlast, s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid, m_tlast, m_ready;
  logic [DW-1:0] m_data;
  logic [31:0]   pkt_count, beat_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axis_pixel_proc #(.DATA_WIDTH(DW), .LANE_WIDTH(LW)) dut (
    .axi_clk      (clk),
    .axi_reset    (axi_reset),
    .cfg_mode     (cfg_mode),
    .cfg_operand  (cfg_operand),
    .s_axis_valid (s_valid),
    .s_axis_data  (s_data),
    .s_axis_tlast (s_tlast),
    .s_axis_ready (s_ready),
    .m_axis_valid (m_valid),
    .m_axis_data  (m_data),
    .m_axis_tlast (m_tlast),
    .m_axis_ready (m_ready),
    .pkt_count    (pkt_count),
    .beat_count   (beat_count)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_px(input logic [1:0] mode, input logic [7:0] op,
                                         input logic [31:0] d);
    logic [31:0] r;
    int x, y;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = int'(d[8*i +: 8]);
      case (mode)
        2'd0:    y = x;
        2'd1:    y = 255 - x;
        2'd2:    y = (x >= int'(op)) ? 255 : 0;
        default: begin y = x + int'(op); if (y > 255) y = 255; end
      endcase
      r[8*i +: 8] = y[7:0];
    end
    return r;
  endfunction

  task automatic do_reset();
    axi_reset = 1'b1; s_valid = 1'b0; s_tlast = 1'b0; s_data = '0; m_ready = 1'b1;
    tick(); tick();
    axi_reset = 1'b0;
  endtask

  task automatic test_reset();
    cfg_mode = 2'd0; cfg_operand = '0;
    do_reset();
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
    n_vec++; if (m_data !== 32'h0) begin n_bad++; $display("FAIL reset_m_data got=%08h exp=0", m_data); end
    n_vec++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_m_tlast got=%0b exp=0", m_tlast); end
    n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
    n_vec++; if (beat_count !== 32'd0 || pkt_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", beat_count, pkt_count);
    end
  endtask

  task automatic test_invert();
    logic [31:0] din [4];
    logic [31:0] dexp [4];
    din  = '{32'h00FF7F80, 32'h12345678, 32'h00000000, 32'hFFFFFFFF};
    dexp = '{32'hFF00807F, 32'hEDCBA987, 32'hFFFFFFFF, 32'h00000000};
    cfg_mode = 2'b01; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = din[i]; s_tlast = (i == 3);
      n_vec++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL invert_ready beat=%0d got=0 exp=1", i); end
      tick();
      n_vec++; if (m_valid !== 1'b1 || m_data !== dexp[i] || m_tlast !== (i == 3)) begin
        n_bad++; $display("FAIL invert_beat%0d got v=%0b d=%08h l=%0b exp v=1 d=%08h l=%0b",
                          i, m_valid, m_data, m_tlast, dexp[i], (i == 3));
      end
    end
    s_valid = 1'b0; s_tlast = 1'b0;
    tick();
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL invert_drained got v=%0b exp=0", m_valid); end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  op;
    logic [31:0] din;
    logic [31:0] dexp;
  } vec_t;

  task automatic test_ops();
    vec_t tbl [7];
    tbl = '{'{2'd3, 8'h20, 32'hF0E01020, 32'hFFFF3040},
            '{2'd2, 8'h80, 32'h7F80FF00, 32'h00FFFF00},
            '{2'd3, 8'h20, 32'hDF00FF01, 32'hFF20FF21},
            '{2'd2, 8'h00, 32'h00123456, 32'hFFFFFFFF},
            '{2'd2, 8'hFF, 32'hFEFF00FF, 32'h00FF00FF},
            '{2'd0, 8'h55, 32'hA5A55A5A, 32'hA5A55A5A},
            '{2'd3, 8'h00, 32'h12345678, 32'h12345678}};
    m_ready = 1'b1;
    foreach (tbl[i]) begin
      cfg_mode = tbl[i].mode; cfg_operand = tbl[i].op;
      s_valid = 1'b1; s_data = tbl[i].din; s_tlast = 1'b1;
      tick();
      s_valid = 1'b0; s_tlast = 1'b0;
      n_vec++; if (m_valid !== 1'b1 || m_data !== tbl[i].dexp || m_tlast !== 1'b1) begin
        n_bad++; $display("FAIL ops_vec%0d got v=%0b d=%08h l=%0b exp v=1 d=%08h l=1",
                          i, m_valid, m_data, m_tlast, tbl[i].dexp);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic        rdy [12];
    logic [31:0] prev_data;
    logic        prev_stall;
    logic        acc, drn;
    int k, nexp;
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    cfg_mode = 2'd0; k = 0; nexp = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 16; c++) begin
      m_ready = (c < 12) ? rdy[c] : 1'b1;
      s_valid = (k < 6); s_data = 32'hC0DE0000 + k; s_tlast = (k == 5);
      if (prev_stall) begin
        n_vec++; if (m_data !== prev_data) begin
          n_bad++; $display("FAIL bp_hold c=%0d got=%08h exp=%08h", c, m_data, prev_data);
        end
      end
      acc = s_valid && s_ready;
      drn = m_valid && m_ready;
      if (drn) begin
        n_vec++; if (m_data !== 32'hC0DE0000 + nexp || m_tlast !== (nexp == 5)) begin
          n_bad++; $display("FAIL bp_order idx=%0d got d=%08h l=%0b exp d=%08h l=%0b",
                            nexp, m_data, m_tlast, 32'hC0DE0000 + nexp, (nexp == 5));
        end
        nexp++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick();
      if (acc) k++;
      if (c < 8) begin
        n_vec++; if (s_ready !== !(c >= 1 && c <= 3)) begin
          n_bad++; $display("FAIL bp_ready after_edge=%0d got=%0b exp=%0b", c, s_ready, !(c >= 1 && c <= 3));
        end
      end
    end
    s_valid = 1'b0; s_tlast = 1'b0;
    n_vec++; if (nexp !== 6 || k !== 6) begin
      n_bad++; $display("FAIL bp_count got drained=%0d accepted=%0d exp=6/6", nexp, k);
    end
  endtask

  task automatic test_random();
    logic [32:0] q [$];
    logic [32:0] e;
    logic [1:0]  pm;
    logic [7:0]  po;
    logic        in_pkt, acc, drn, prev_stall;
    logic [31:0] prev_data;
    int sent, cyc;
    sent = 0; cyc = 0; in_pkt = 1'b0; prev_stall = 1'b0; prev_data = '0; pm = '0; po = '0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      cfg_mode    = 2'($urandom_range(0, 3));
      cfg_operand = 8'($urandom_range(0, 255));
      m_ready     = ($urandom_range(0, 3) != 0);
      s_valid     = (sent < 1000) && ($urandom_range(0, 4) != 0);
      s_data      = $urandom;
      s_tlast     = (sent == 999) || ($urandom_range(0, 3) == 0);
      if (prev_stall) begin
        n_vec++; if (m_data !== prev_data) begin
          n_bad++; $display("FAIL rand_hold cyc=%0d got=%08h exp=%08h", cyc, m_data, prev_data);
        end
      end
      acc = s_valid && s_ready;
      drn = m_valid && m_ready;
      if (acc) begin
        if (!in_pkt) begin pm = cfg_mode; po = cfg_operand; end
        q.push_back({s_tlast, ref_px(pm, po, s_data)});
        in_pkt = !s_tlast;
        sent++;
      end
      if (drn) begin
        if (q.size() == 0) begin
          n_vec++; n_bad++; $display("FAIL rand_extra cyc=%0d got d=%08h exp=none", cyc, m_data);
        end else begin
          e = q.pop_front();
          n_vec++; if ({m_tlast, m_data} !== e) begin
            n_bad++; $display("FAIL rand_beat cyc=%0d got l=%0b d=%08h exp l=%0b d=%08h",
                              cyc, m_tlast, m_data, e[32], e[31:0]);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick();
      cyc++;
    end
    s_valid = 1'b0; s_tlast = 1'b0; m_ready = 1'b1;
    n_vec++; if (sent != 1000 || q.size() != 0) begin
      n_bad++; $display("FAIL rand_timeout got sent=%0d pending=%0d exp=1000/0", sent, q.size());
    end
    tick();
  endtask

  task automatic test_cfg_switch();
    logic [31:0] din [6];
    din = '{32'h01020304, 32'h80FF007F, 32'hA0B0C0D0, 32'h11223344, 32'h5A5A0F0F, 32'hDEADBEEF};
    m_ready = 1'b1; cfg_mode = 2'b01; cfg_operand = 8'h00;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) cfg_mode = 2'b00;
      s_valid = 1'b1; s_data = din[i]; s_tlast = (i == 3) || (i == 5);
      tick();
      n_vec++; if (m_data !== ((i < 4) ? ~din[i] : din[i])) begin
        n_bad++; $display("FAIL cfgsw_beat%0d got=%08h exp=%08h", i, m_data, (i < 4) ? ~din[i] : din[i]);
      end
    end
    s_valid = 1'b0; s_tlast = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0; cfg_mode = 2'b00;
    s_valid = 1'b1; s_data = 32'h11111111; s_tlast = 1'b0;
    tick();
    s_data = 32'h22222222;
    tick();
    s_valid = 1'b0;
    n_vec++; if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_full got rdy=%0b v=%0b exp rdy=0 v=1", s_ready, m_valid);
    end
    axi_reset = 1'b1;
    tick();
    axi_reset = 1'b0;
    n_vec++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_state got v=%0b rdy=%0b d=%08h exp v=0 rdy=1 d=0", m_valid, s_ready, m_data);
    end
    n_vec++; if (beat_count !== 32'd0 || pkt_count !== 32'd0) begin
      n_bad++; $display("FAIL rstmid_counters got=%0d/%0d exp=0/0", beat_count, pkt_count);
    end
    m_ready = 1'b1; cfg_mode = 2'b01;
    s_valid = 1'b1; s_data = 32'h0F0F3C00; s_tlast = 1'b1;
    tick();
    s_valid = 1'b0; s_tlast = 1'b0;
    n_vec++; if (m_valid !== 1'b1 || m_data !== 32'hF0F0C3FF || m_tlast !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_next got v=%0b d=%08h l=%0b exp v=1 d=F0F0C3FF l=1", m_valid, m_data, m_tlast);
    end
    tick();
    n_vec++; if (m_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_stale got v=%0b d=%08h exp v=0", m_valid, m_data);
    end
  endtask

  task automatic test_stats();
    int lens [3];
    logic [31:0] exp_beats, exp_pkts;
    lens = '{5, 1, 2};
`ifdef AXIS_PIXEL_PROC_STATS_EN
    exp_beats = 32'd8; exp_pkts = 32'd3;
`else
    exp_beats = 32'd0; exp_pkts = 32'd0;
`endif
    do_reset();
    cfg_mode = 2'b00; m_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < lens[p]; b++) begin
        s_valid = 1'b1; s_data = 32'h100 * p + b; s_tlast = (b == lens[p] - 1);
        tick();
      end
    end
    s_valid = 1'b0; s_tlast = 1'b0;
    tick(); tick();
    n_vec++; if (beat_count !== exp_beats) begin
      n_bad++; $display("FAIL stats_beats got=%0d exp=%0d", beat_count, exp_beats);
    end
    n_vec++; if (pkt_count !== exp_pkts) begin
      n_bad++; $display("FAIL stats_pkts got=%0d exp=%0d", pkt_count, exp_pkts);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_invert();
    test_ops();
    test_backpressure();
    test_cfg_switch();
    test_random();
    test_reset_mid();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_pixel_proc.md
Name: axis_pixel_proc

Overview:
Parametrised AXI4-Stream per-lane pixel processor; next generation of the byte-inverter in the DMA loopback path (S2MM <- block <- MM2S).
- Applies a runtime-selectable per-lane operation: pass, invert, threshold or saturating add.
- Registered skid-buffer handshake gives full throughput with correct backpressure.
- Mode and operand are latched per packet, so frames are never processed with mixed settings.

Parameters:
DATA_WIDTH, 32, stream data width in bits; must be a multiple of LANE_WIDTH.
LANE_WIDTH, 8, width of one pixel lane; NLANES = DATA_WIDTH/LANE_WIDTH.

Ports:
axi_clk  input  1  clock; all logic on its rising edge.
axi_reset  input  1  synchronous, active-high reset.
cfg_mode  input  2  operation select: 00 pass, 01 invert, 10 threshold, 11 saturating add.
cfg_operand  input  LANE_WIDTH  threshold level (mode 10) or addend (mode 11).
s_axis_valid  input  1  slave beat valid.
s_axis_data  input  DATA_WIDTH  slave beat data.
s_axis_tlast  input  1  last beat of packet.
s_axis_ready  output  1  slave ready.
m_axis_valid  output  1  master beat valid.
m_axis_data  output  DATA_WIDTH  processed data.
m_axis_tlast  output  1  forwarded tlast.
m_axis_ready  input  1  master ready.
pkt_count  output  32  packets completed on the master side (optional feature).
beat_count  output  32  beats completed on the master side (optional feature).

Behaviour:
- Reset values: m_axis_valid=0, m_axis_data=0, m_axis_tlast=0, s_axis_ready=1 (after the reset cycle), skid empty, counters 0, FSM=IDLE. Reset mid-packet discards all held beats; the next accepted beat starts a new packet.
- Handshake: beat transfers when valid && ready on the same edge.
  - s_axis_ready is a register and equals !skid_valid; it never depends combinationally on m_axis_ready.
  - m_axis_valid and m_axis_data are stable while m_axis_valid && !m_axis_ready.
- Datapath: one output register plus one skid register.
  - Beat accepted in cycle N appears on m_axis in cycle N+1 if the output register is empty or draining in cycle N.
  - Otherwise the beat goes to the skid register and s_axis_ready drops in cycle N+1.
  - When the output drains, skid moves to the output and ready returns to 1 the next cycle.
  - Sustained 1 beat/cycle while m_axis_ready=1.
- Simultaneous input accept and output drain with skid empty: new beat loads the output register directly. No bubble, no drop.
- Operation is combinational on s_axis_data, per lane i in 0..NLANES-1 (x = lane, MAX = 2^LANE_WIDTH-1):
  - 00: y=x.
  - 01: y=MAX-x.
  - 10: y = (x >= operand) ? MAX : 0.
  - 11: y = min(x+operand, MAX), computed at LANE_WIDTH+1 bits then clamped.
  - Result is registered into the output or skid register together with tlast.
- Config latch FSM:
  - IDLE: on an accepted beat, capture cfg_mode/cfg_operand into active registers and use the live values for that beat. Go to IN_PKT, or stay in IDLE if tlast=1 (single-beat packet).
  - IN_PKT: use the active registers; cfg changes are ignored. On an accepted tlast beat, go to IDLE.
- Packet boundaries are defined on the slave side (accept time); tlast is propagated unchanged through both registers.

Optional Feature:
Macro AXIS_PIXEL_PROC_STATS_EN.
- Defined: beat_count increments on each master-side transfer. pkt_count increments on each master-side transfer with m_axis_tlast=1. Both are 32-bit, wrap from FFFFFFFF to 0, and clear on reset.
- Undefined: the counter logic is removed and both ports are tied to 0.

Test Plan:
- Invert, DATA_WIDTH=32, m_axis_ready=1, 4-beat packet 0x00FF7F80, 0x12345678, 0, 0xFFFFFFFF -> 0xFF0080 7F, 0xEDCBA987, 0xFFFFFFFF, 0x00000000, one cycle after each accept; tlast only on the 4th beat; no ready gaps.
- Saturating add, operand=0x20, beat 0xF0E01020 -> 0xFFFF3040; threshold, operand=0x80, beat 0x7F80FF00 -> 0x00FFFF00.
- Backpressure: continuous input; m_axis_ready low for 3 cycles -> s_axis_ready drops the cycle after the skid fills, no beat lost or duplicated, m_axis_data held stable, order preserved; random ready over 1000 beats matches the reference model.
- Config switch mid-packet: cfg_mode 01→00 at beat 2 of 4 -> all 4 beats inverted; the next packet is passed through.
- Reset asserted with output and skid full -> next cycle m_axis_valid=0, s_axis_ready=1, counters 0; the following packet is processed correctly.
- With AXIS_PIXEL_PROC_STATS_EN defined: 3 packets of 5, 1 and 2 beats -> beat_count=8, pkt_count=3; with the macro undefined, both counters read 0.
